// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID register, honouring EX-stage redirects, hazard stalls and memory wait.
module fetch_pc_unit #(
    parameter int unsigned PC_W     = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    input  logic            imem_rdy,
    input  logic [31:0]     Instr_in,
    output logic [PC_W-1:0] Instr_Addr,
    output logic [PC_W-1:0] IfId_PC,
    output logic [31:0]     IfId_Instr,
    output logic            IfId_Valid,
    output logic            misalign,
    output logic [15:0]     redirect_cnt
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            misalign_q, misalign_d;
    logic [15:0]     redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        pc_d           = pc_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_valid_d   = ifid_valid_q;
        misalign_d     = 1'b0;
        redirect_cnt_d = redirect_cnt_q;

        if (PcSel) begin
            // Redirect overrides stall and memory wait; the word in flight is squashed.
            pc_d           = {BrPC[PC_W-1:2], 2'b00};
            ifid_pc_d      = pc_q;
            ifid_instr_d   = NOP;
            ifid_valid_d   = 1'b0;
            misalign_d     = (BrPC[1:0] != 2'b00) || (BrPC[31:PC_W] != '0);
            redirect_cnt_d = (redirect_cnt_q == 16'hFFFF) ? redirect_cnt_q
                                                           : redirect_cnt_q + 16'd1;
        end else if (stall) begin
            // Hold everything.
        end else if (!imem_rdy) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = Instr_in;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + PC_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC[PC_W-1:0];
            ifid_pc_q      <= '0;
            ifid_instr_q   <= NOP;
            ifid_valid_q   <= 1'b0;
            misalign_q     <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            pc_q           <= pc_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_valid_q   <= ifid_valid_d;
            misalign_q     <= misalign_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign Instr_Addr   = pc_q;
    assign IfId_PC      = ifid_pc_q;
    assign IfId_Instr   = ifid_instr_q;
    assign IfId_Valid   = ifid_valid_q;
    assign misalign     = misalign_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: a behavioural model pushes expected state
// into a scoreboard queue at drive time; entries are popped and compared after the edge.
module tb_fetch_pc_unit;

    localparam int unsigned PC_W = 9;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            stall;
    logic            imem_rdy;
    logic [31:0]     Instr_in;
    logic [PC_W-1:0] Instr_Addr;
    logic [PC_W-1:0] IfId_PC;
    logic [31:0]     IfId_Instr;
    logic            IfId_Valid;
    logic            misalign;
    logic [15:0]     redirect_cnt;

    fetch_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PcSel        (PcSel),
        .BrPC         (BrPC),
        .stall        (stall),
        .imem_rdy     (imem_rdy),
        .Instr_in     (Instr_in),
        .Instr_Addr   (Instr_Addr),
        .IfId_PC      (IfId_PC),
        .IfId_Instr   (IfId_Instr),
        .IfId_Valid   (IfId_Valid),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] ifid_pc;
        logic [31:0]     instr;
        logic            valid;
        logic            mis;
        logic [15:0]     cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_ipc;
    logic [31:0]     m_instr;
    logic            m_valid;
    logic            m_mis;
    logic [15:0]     m_cnt;

    function automatic logic [31:0] imem(input logic [PC_W-1:0] a);
        return {16'hA5A5, 7'd0, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus (called at negedge), push expectation, compare after edge.
    task automatic step(input string tag, input logic rst, input logic pcs,
                        input logic [31:0] br, input logic stl, input logic rdy);
        exp_t e;
        exp_t got;
        logic [8:0] tgt;
        reset    = rst;
        PcSel    = pcs;
        BrPC     = br;
        stall    = stl;
        imem_rdy = rdy;
        Instr_in = rdy ? imem(m_pc) : 32'hDEAD_BEEF;

        tgt = br[8:0];
        if (rst) begin
            m_pc = '0; m_ipc = '0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'd0;
        end else if (pcs) begin
            m_ipc   = m_pc;
            m_instr = NOP;
            m_valid = 1'b0;
            m_mis   = (br[1:0] != 2'b00) || (br[31:9] != 23'd0);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_pc    = tgt & 9'h1FC;
        end else begin
            m_mis = 1'b0;
            if (!stl) begin
                m_ipc = m_pc;
                if (!rdy) begin
                    m_instr = NOP;
                    m_valid = 1'b0;
                end else begin
                    m_instr = imem(m_pc);
                    m_valid = 1'b1;
                    m_pc    = m_pc + 9'd4;
                end
            end
        end
        e = '{pc: m_pc, ifid_pc: m_ipc, instr: m_instr, valid: m_valid, mis: m_mis, cnt: m_cnt};
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq({tag, ".addr"},  32'(Instr_Addr),   32'(got.pc));
        check_eq({tag, ".ifpc"},  32'(IfId_PC),      32'(got.ifid_pc));
        check_eq({tag, ".instr"}, IfId_Instr,        got.instr);
        check_eq({tag, ".valid"}, 32'(IfId_Valid),   32'(got.valid));
        check_eq({tag, ".mis"},   32'(misalign),     32'(got.mis));
        check_eq({tag, ".cnt"},   32'(redirect_cnt), 32'(got.cnt));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PcSel = 1'b0; BrPC = '0; stall = 1'b0; imem_rdy = 1'b0; Instr_in = '0;
        m_pc = '0; m_ipc = '0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;
        @(negedge clk);

        step("rst", 1, 0, 0, 0, 0);
        check_eq("rst_addr",  32'(Instr_Addr), 32'h0);
        check_eq("rst_instr", IfId_Instr, NOP);
        check_eq("rst_valid", 32'(IfId_Valid), 32'h0);
        check_eq("rst_cnt",   32'(redirect_cnt), 32'h0);

        for (int i = 0; i < 4; i++) step("fetch", 0, 0, 0, 0, 1);
        check_eq("seq_addr",  32'(Instr_Addr), 32'h010);
        check_eq("seq_ifpc",  32'(IfId_PC), 32'h00C);
        check_eq("seq_instr", IfId_Instr, 32'hA5A5_000C);

        step("redir40", 0, 1, 32'h0000_0040, 0, 1);
        check_eq("redir40_addr",  32'(Instr_Addr), 32'h040);
        check_eq("redir40_valid", 32'(IfId_Valid), 32'h0);
        check_eq("redir40_cnt",   32'(redirect_cnt), 32'h1);
        check_eq("redir40_mis",   32'(misalign), 32'h0);
        step("after40", 0, 0, 0, 0, 1);
        check_eq("after40_valid", 32'(IfId_Valid), 32'h1);

        step("redir42", 0, 1, 32'h0000_0042, 0, 1);
        check_eq("redir42_addr", 32'(Instr_Addr), 32'h040);
        check_eq("redir42_mis",  32'(misalign), 32'h1);
        step("redir400", 0, 1, 32'h0000_0400, 0, 1);
        check_eq("redir400_addr", 32'(Instr_Addr), 32'h000);
        check_eq("redir400_mis",  32'(misalign), 32'h1);
        check_eq("redir400_cnt",  32'(redirect_cnt), 32'h3);
        step("clrmis", 0, 0, 0, 0, 1);
        check_eq("clrmis_mis", 32'(misalign), 32'h0);
        step("fetch", 0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 1, 1);
        check_eq("stall_addr", 32'(Instr_Addr), 32'h008);
        step("stallredir", 0, 1, 32'h0000_0080, 1, 1);
        check_eq("stallredir_addr",  32'(Instr_Addr), 32'h080);
        check_eq("stallredir_valid", 32'(IfId_Valid), 32'h0);
        step("fetch", 0, 0, 0, 0, 1);

        step("nrdy", 0, 0, 0, 0, 0);
        step("nrdy", 0, 0, 0, 0, 0);
        check_eq("nrdy_addr",  32'(Instr_Addr), 32'h084);
        check_eq("nrdy_instr", IfId_Instr, NOP);
        step("recover", 0, 0, 0, 0, 1);
        check_eq("recover_ifpc",  32'(IfId_PC), 32'h084);
        check_eq("recover_instr", IfId_Instr, 32'hA5A5_0084);

        force dut.redirect_cnt_q = 16'hFFFE;
        #1;
        release dut.redirect_cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) step("sat", 0, 1, 32'h0000_0100, 0, 1);
        check_eq("sat_cnt", 32'(redirect_cnt), 32'hFFFF);

        step("to1fc", 0, 1, 32'h0000_01FC, 0, 1);
        step("wrap", 0, 0, 0, 0, 1);
        check_eq("wrap_addr", 32'(Instr_Addr), 32'h000);
        check_eq("wrap_ifpc", 32'(IfId_PC), 32'h1FC);
        step("fetch", 0, 0, 0, 0, 1);

        step("prestall", 0, 0, 0, 1, 1);
        step("rststall", 1, 1, 32'h0000_0040, 1, 1);
        check_eq("rststall_addr",  32'(Instr_Addr), 32'h000);
        check_eq("rststall_ifpc",  32'(IfId_PC), 32'h000);
        check_eq("rststall_instr", IfId_Instr, NOP);
        check_eq("rststall_cnt",   32'(redirect_cnt), 32'h0);
        step("postrst", 0, 0, 0, 0, 1);
        check_eq("postrst_instr", IfId_Instr, 32'hA5A5_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the pipelined RV32 core. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It consumes the redirect outputs (PcSel, BrPC) of the EX-stage branch unit, which sits downstream of it. Its IfId_PC output is the PC that travels down the pipe and arrives at the branch unit as Cur_PC.

## Interface
Parameters:
- PC_W, 9: program counter width in bits, matching the branch unit's Cur_PC width.
- RESET_PC, 0: PC value loaded on reset. Must be a multiple of 4.
- NOP, 32'h00000013: bubble instruction (addi x0,x0,0) inserted into IF/ID.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- PcSel  in  1  redirect request from the branch unit (branch or jalr taken).
- BrPC  in  32  redirect target from the branch unit.
- stall  in  1  hold request from the hazard unit (load-use).
- imem_rdy  in  1  instruction memory has valid data on Instr_in this cycle.
- Instr_in  in  32  instruction word read at Instr_Addr.
- Instr_Addr  out  PC_W  current fetch address; equal to the PC register.
- IfId_PC  out  PC_W  PC of the instruction in IF/ID.
- IfId_Instr  out  32  instruction in IF/ID.
- IfId_Valid  out  1  IF/ID holds a real instruction (0 means bubble).
- misalign  out  1  one-cycle pulse: the last accepted redirect target was bad.
- redirect_cnt  out  16  saturating count of accepted redirects.

## Operation
- State: PC register, IF/ID register (PC, instr, valid), misalign flag, redirect counter.
- Reset values: PC=RESET_PC, IfId_PC=0, IfId_Instr=NOP, IfId_Valid=0, misalign=0, redirect_cnt=0.
- One condition acts per cycle, in strict priority order: reset > PcSel > stall > !imem_rdy > normal fetch.
- Redirect (PcSel=1):
  - PC <= {BrPC[PC_W-1:2], 2'b00}.
  - IF/ID <= {PC, NOP, valid=0}, which squashes the instruction currently being fetched.
  - This applies even when stall=1 or imem_rdy=0.
  - redirect_cnt increments and saturates at 16'hFFFF.
  - misalign <= (BrPC[1:0]!=0) || (BrPC[31:PC_W]!=0).
- Stall (stall=1, PcSel=0): PC and the whole IF/ID register hold.
- Memory not ready (imem_rdy=0, stall=0, PcSel=0):
  - PC holds.
  - IF/ID <= {PC, NOP, valid=0}, a bubble.
- Normal fetch:
  - IfId_PC <= PC, IfId_Instr <= Instr_in, IfId_Valid <= 1.
  - PC <= PC + 4, wrapping modulo 2^PC_W.
- misalign is cleared on every cycle without an accepted redirect.
- Instr_Addr is a direct output of the PC register; there is no combinational path from PcSel or BrPC to Instr_Addr.

## Timing
- Fetch latency: an instruction presented on Instr_in in cycle N appears on IfId_* in cycle N+1.
- Redirect latency: PcSel sampled high at edge N gives Instr_Addr = target in cycle N+1. The first target instruction reaches IF/ID at edge N+1, or later if imem_rdy=0.
- Redirect bubbles: after a redirect, IfId_Valid is 0 for exactly the one cycle following the redirect edge, provided imem_rdy=1.
- Back-to-back redirects on consecutive cycles: the later one wins. Each one counts, and each produces a bubble.
- Redirect with stall=1 in the same cycle: the redirect takes effect and the stall is ignored for that cycle. The hazard unit re-asserts stall if it still needs it.
- PC wrap: with PC=2^PC_W-4 and a normal fetch, next PC=0. Wrap is not an error.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at that edge. The first fetch after reset deasserts is at RESET_PC.
- Throughput: one instruction per cycle with imem_rdy=1, stall=0, PcSel=0.

## Test plan
- Reset, then 4 cycles with imem_rdy=1 and Instr_in=instr(addr) → Instr_Addr 0,4,8,12. IF/ID gets {0,instr0,1},{4,instr1,1},... one cycle behind.
- At PC=0x010, assert PcSel=1, BrPC=0x0000_0040 → next Instr_Addr=0x040, IfId_Valid=0 for one cycle, redirect_cnt=1, misalign=0.
- PcSel=1 with BrPC=0x0000_0042, then BrPC=0x0000_0400 (PC_W=9) → Instr_Addr=0x040 and then 0x000, misalign pulses on each redirect, count increments by 2.
- stall=1 for 3 cycles with PcSel=0 → PC and IF/ID frozen. Then stall=1 together with PcSel=1 → redirect taken, IF/ID bubble.
- imem_rdy=0 for 2 cycles → PC holds, IfId_Valid=0, IfId_Instr=NOP. Recovery resumes at the same address with no skipped word.
- Force redirect_cnt to 16'hFFFE and apply 3 redirects → count stops at 16'hFFFF. Then start from PC=0x1FC with a normal fetch → next PC=0x000. Reset during a stall → all outputs return to reset values.
